// File: rtl/fcims_txn_ctrl.sv
// fcims_txn_ctrl
// Stock/till transaction controller. A request either takes items out of
// stock, which adds qty*uprice to the running total, or returns items to
// stock, which subtracts qty*uprice from the total. The price is formed by a
// 4-cycle shift-add multiplier. Any request that would wrap count or total is
// rejected with an error code. A rejected request leaves count and total as
// they were.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high; clears all state and aborts work
//   load         loads count/total from load_ct/load_total (IDLE only)
//   load_ct      [3:0] initial stock count
//   load_total   [7:0] initial running total
//   req_valid    request present
//   req_ready    request can be accepted this cycle (IDLE and no load)
//   req_op       1 = take (stock down, total up), 0 = return
//   req_qty      [3:0] item quantity
//   req_uprice   [3:0] unit price
//   resp_valid   one-cycle pulse: result available
//   resp_err     [1:0] 00 ok, 01 stock underflow, 10 total underflow,
//                11 overflow
//   resp_price   [7:0] qty*uprice of the last completed request (held)
//   count        [3:0] registered stock count
//   total        [7:0] registered running total
//   empty        count == 0
//   busy         FSM not in IDLE
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both 1. The op, qty and uprice are captured on that edge and
// ignored afterwards. The response comes back as a single resp_valid pulse
// with no back-pressure, in the 6th cycle counted from the accept edge.
// A new request can be accepted every 7 cycles.

module fcims_txn_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_ct,
    input  logic [7:0] load_total,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_op,
    input  logic [3:0] req_qty,
    input  logic [3:0] req_uprice,
    output logic       resp_valid,
    output logic [1:0] resp_err,
    output logic [7:0] resp_price,
    output logic [3:0] count,
    output logic [7:0] total,
    output logic       empty,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_CHECK = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t     r_state;
    logic       r_op;
    logic [3:0] r_qty;       // unshifted copy of qty for the check/update
    logic [3:0] r_mplier;    // qty, consumed LSB first
    logic [7:0] r_mcand;     // uprice, shifted left once per MUL cycle
    logic [7:0] r_prod;
    logic [1:0] r_mul_cnt;
    logic [3:0] r_count;
    logic [7:0] r_total;
    logic       r_resp_valid;
    logic [1:0] r_resp_err;
    logic [7:0] r_resp_price;

    logic       w_accept;
    logic [7:0] w_prod_next;
    logic [8:0] w_sum_total;
    logic [4:0] w_sum_count;
    logic [1:0] w_err;

    assign req_ready  = (r_state == S_IDLE) && !load;
    assign w_accept   = req_valid && req_ready;
    assign busy       = (r_state != S_IDLE);
    assign empty      = (r_count == 4'd0);
    assign count      = r_count;
    assign total      = r_total;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_price = r_resp_price;

    // The largest product is 15*15 = 225, so the 8-bit accumulator never
    // overflows.
    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : 8'd0);

    // The sums are one bit wider than the operands. The top bit then flags a
    // result that would not fit in the register.
    assign w_sum_total = {1'b0, r_total} + {1'b0, r_prod};
    assign w_sum_count = {1'b0, r_count} + {1'b0, r_qty};

    // Error priority: for a take, a stock underflow is reported before a
    // total overflow. For a return, a count overflow is reported before a
    // total underflow.
    always_comb begin
        w_err = 2'b00;
        if (r_op) begin
            if (r_qty > r_count) begin
                w_err = 2'b01;
            end else if (w_sum_total[8]) begin
                w_err = 2'b11;
            end
        end else begin
            if (w_sum_count[4]) begin
                w_err = 2'b11;
            end else if (r_prod > r_total) begin
                w_err = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_op         <= 1'b0;
            r_qty        <= 4'd0;
            r_mplier     <= 4'd0;
            r_mcand      <= 8'd0;
            r_prod       <= 8'd0;
            r_mul_cnt    <= 2'd0;
            r_count      <= 4'd0;
            r_total      <= 8'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 2'b00;
            r_resp_price <= 8'd0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_count <= load_ct;
                        r_total <= load_total;
                    end else if (w_accept) begin
                        r_op      <= req_op;
                        r_qty     <= req_qty;
                        r_mplier  <= req_qty;
                        r_mcand   <= {4'd0, req_uprice};
                        r_prod    <= 8'd0;
                        r_mul_cnt <= 2'd0;
                        r_state   <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_prod    <= w_prod_next;
                    r_mcand   <= {r_mcand[6:0], 1'b0};
                    r_mplier  <= {1'b0, r_mplier[3:1]};
                    r_mul_cnt <= r_mul_cnt + 2'd1;
                    if (r_mul_cnt == 2'd3) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= w_err;
                    r_resp_price <= r_prod;
                    if (w_err == 2'b00) begin
                        if (r_op) begin
                            r_count <= r_count - r_qty;
                            r_total <= w_sum_total[7:0];
                        end else begin
                            r_count <= w_sum_count[3:0];
                            r_total <= r_total - r_prod;
                        end
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fcims_txn_ctrl.sv
module tb_fcims_txn_ctrl;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] load_ct;
    logic [7:0] load_total;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [3:0] req_qty;
    logic [3:0] req_uprice;
    logic       resp_valid;
    logic [1:0] resp_err;
    logic [7:0] resp_price;
    logic [3:0] count;
    logic [7:0] total;
    logic       empty;
    logic       busy;

    always #5 clk = ~clk;

    fcims_txn_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_ct    (load_ct),
        .load_total (load_total),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_qty    (req_qty),
        .req_uprice (req_uprice),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_price (resp_price),
        .count      (count),
        .total      (total),
        .empty      (empty),
        .busy       (busy)
    );

    int total_n = 0;
    int bad_n   = 0;

    // ---------------- reference model ----------------
    int m_count;
    int m_total;

    task automatic model_txn(input bit op, input int qty, input int up,
                             output int err, output int price);
        price = qty * up;
        err   = 0;
        if (op) begin
            if (qty > m_count)              err = 1;
            else if (m_total + price > 255) err = 3;
            else begin
                m_count = m_count - qty;
                m_total = m_total + price;
            end
        end else begin
            if (m_count + qty > 15)         err = 3;
            else if (price > m_total)       err = 2;
            else begin
                m_count = m_count + qty;
                m_total = m_total - price;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge. Returns at the falling edge of cycle 7, when
    // the block should be idle again.
    task automatic run_txn(input bit op, input int qty, input int up, input bit ld_busy,
                           output bit acc, output int first, output int pulses,
                           output logic [1:0] o_err, output logic [7:0] o_price,
                           output logic [3:0] o_cnt, output logic [7:0] o_tot,
                           output logic o_empty, output bit busy_bad,
                           output bit rdy_after, output time t_acc);
        first = 0; pulses = 0; busy_bad = 0; rdy_after = 0;
        o_err = 'x; o_price = 'x; o_cnt = 'x; o_tot = 'x; o_empty = 'x;
        req_valid  = 1'b1;
        req_op     = op;
        req_qty    = 4'(qty);
        req_uprice = 4'(up);
        acc = (req_ready === 1'b1);
        @(posedge clk);
        t_acc = $time;
        #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            // After the accept edge the request fields are scrambled to show
            // that they are not sampled again.
            req_op     = 1'($urandom);
            req_qty    = 4'($urandom);
            req_uprice = 4'($urandom);
            if (ld_busy && c == 2) begin
                load       = 1'b1;
                load_ct    = 4'($urandom);
                load_total = 8'($urandom);
            end
            if (ld_busy && c == 3) load = 1'b0;
            @(negedge clk);
            if (c <= 5 && (busy !== 1'b1 || req_ready !== 1'b0)) busy_bad = 1;
            if (resp_valid === 1'b1) begin
                pulses++;
                if (first == 0) begin
                    first   = c;
                    o_err   = resp_err;
                    o_price = resp_price;
                    o_cnt   = count;
                    o_tot   = total;
                    o_empty = empty;
                end
            end
            if (c == 7) rdy_after = (req_ready === 1'b1) && (busy === 1'b0);
        end
        load = 1'b0;
    endtask

    // Called at a falling edge; returns at the following falling edge.
    task automatic do_load(input int ct, input int tot, input bit with_req, output bit rdy);
        load       = 1'b1;
        load_ct    = 4'(ct);
        load_total = 8'(tot);
        req_valid  = with_req;
        req_op     = 1'($urandom);
        req_qty    = 4'($urandom);
        req_uprice = 4'($urandom);
        #1;
        rdy = req_ready;
        @(posedge clk);
        #1;
        load      = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        m_count = ct;
        m_total = tot;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; load = 1'b1; load_ct = 4'd9; load_total = 8'd99;
        req_valid = 1'b1; req_op = 1'b1; req_qty = 4'd1; req_uprice = 4'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; load = 1'b0; req_valid = 1'b0;
        #1;
        m_count = 0; m_total = 0;
        total_n++; if (count !== 4'd0)      begin bad_n++; $display("FAIL reset_count got %0d want 0", count); end
        total_n++; if (total !== 8'd0)      begin bad_n++; $display("FAIL reset_total got %0d want 0", total); end
        total_n++; if (resp_valid !== 1'b0) begin bad_n++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        total_n++; if (resp_err !== 2'b00)  begin bad_n++; $display("FAIL reset_resp_err got %b want 00", resp_err); end
        total_n++; if (resp_price !== 8'd0) begin bad_n++; $display("FAIL reset_resp_price got %0d want 0", resp_price); end
        total_n++; if (busy !== 1'b0)       begin bad_n++; $display("FAIL reset_busy got %b want 0", busy); end
        total_n++; if (req_ready !== 1'b1)  begin bad_n++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        total_n++; if (empty !== 1'b1)      begin bad_n++; $display("FAIL reset_empty got %b want 1", empty); end
    endtask

    typedef struct {
        bit is_load;
        bit op;
        int a;
        int b;
        int e_err;
        int e_price;
    } step_t;

    task automatic test_spec_vectors();
        step_t steps[11];
        bit acc, busy_bad, rdy_after, rdy;
        int first, pulses, e_err, e_price;
        logic [1:0] o_err; logic [7:0] o_price; logic [3:0] o_cnt; logic [7:0] o_tot; logic o_empty;
        time t_acc;
        steps = '{
            '{1'b1, 1'b0, 10,   0, 0,  0},
            '{1'b0, 1'b1,  3,   5, 0, 15},
            '{1'b0, 1'b1,  9,   1, 1,  9},
            '{1'b0, 1'b0,  2,   9, 2, 18},
            '{1'b1, 1'b0, 15, 250, 0,  0},
            '{1'b0, 1'b1,  2,   3, 3,  6},
            '{1'b0, 1'b0,  1,   1, 3,  1},
            '{1'b0, 1'b1,  1,   5, 0,  5},
            '{1'b1, 1'b0,  3,   0, 0,  0},
            '{1'b0, 1'b1,  3,  15, 0, 45},
            '{1'b0, 1'b1,  0,   7, 0,  0}
        };
        for (int i = 0; i < 11; i++) begin
            if (steps[i].is_load) begin
                do_load(steps[i].a, steps[i].b, 1'b0, rdy);
                total_n++;
                if (count !== 4'(m_count) || total !== 8'(m_total)) begin
                    bad_n++; $display("FAIL vec%0d_load got %0d/%0d want %0d/%0d", i, count, total, m_count, m_total);
                end
            end else begin
                run_txn(steps[i].op, steps[i].a, steps[i].b, 1'b0, acc, first, pulses,
                        o_err, o_price, o_cnt, o_tot, o_empty, busy_bad, rdy_after, t_acc);
                model_txn(steps[i].op, steps[i].a, steps[i].b, e_err, e_price);
                total_n++; if (!acc) begin bad_n++; $display("FAIL vec%0d_accept got 0 want 1", i); end
                total_n++; if (first != 6 || pulses != 1) begin
                    bad_n++; $display("FAIL vec%0d_latency got cycle %0d pulses %0d want cycle 6 pulses 1", i, first, pulses);
                end
                total_n++; if (o_err !== 2'(steps[i].e_err)) begin
                    bad_n++; $display("FAIL vec%0d_err got %b want %0d", i, o_err, steps[i].e_err);
                end
                total_n++; if (o_price !== 8'(steps[i].e_price)) begin
                    bad_n++; $display("FAIL vec%0d_price got %0d want %0d", i, o_price, steps[i].e_price);
                end
                total_n++; if (o_cnt !== 4'(m_count) || o_tot !== 8'(m_total)) begin
                    bad_n++; $display("FAIL vec%0d_state got %0d/%0d want %0d/%0d", i, o_cnt, o_tot, m_count, m_total);
                end
                total_n++; if (o_empty !== (m_count == 0)) begin
                    bad_n++; $display("FAIL vec%0d_empty got %b want %b", i, o_empty, (m_count == 0));
                end
                total_n++; if (busy_bad || !rdy_after) begin
                    bad_n++; $display("FAIL vec%0d_busy_ready got bad=%0d rdy_after=%0d want 0/1", i, busy_bad, rdy_after);
                end
            end
        end
    endtask

    task automatic test_load_priority();
        bit rdy;
        do_load(6, 40, 1'b1, rdy);
        total_n++; if (rdy !== 1'b0) begin bad_n++; $display("FAIL load_prio_ready got %b want 0", rdy); end
        total_n++; if (count !== 4'd6 || total !== 8'd40) begin
            bad_n++; $display("FAIL load_prio_values got %0d/%0d want 6/40", count, total);
        end
        repeat (3) @(negedge clk);
        total_n++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            bad_n++; $display("FAIL load_prio_no_accept got busy=%b resp_valid=%b want 0/0", busy, resp_valid);
        end
    endtask

    task automatic test_load_busy();
        bit acc, busy_bad, rdy_after;
        int first, pulses, e_err, e_price;
        logic [1:0] o_err; logic [7:0] o_price; logic [3:0] o_cnt; logic [7:0] o_tot; logic o_empty;
        time t_acc;
        run_txn(1'b1, 2, 4, 1'b1, acc, first, pulses, o_err, o_price, o_cnt, o_tot, o_empty,
                busy_bad, rdy_after, t_acc);
        model_txn(1'b1, 2, 4, e_err, e_price);
        total_n++; if (first != 6 || o_err !== 2'(e_err) || o_price !== 8'(e_price)) begin
            bad_n++; $display("FAIL load_busy_resp got cycle %0d err %b price %0d want 6/%0d/%0d", first, o_err, o_price, e_err, e_price);
        end
        total_n++; if (count !== 4'(m_count) || total !== 8'(m_total)) begin
            bad_n++; $display("FAIL load_busy_ignored got %0d/%0d want %0d/%0d", count, total, m_count, m_total);
        end
    endtask

    task automatic test_reset_abort();
        bit rdy;
        int seen;
        do_load(5, 20, 1'b0, rdy);
        req_valid = 1'b1; req_op = 1'b1; req_qty = 4'd1; req_uprice = 4'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_count = 0; m_total = 0;
        #1;
        total_n++; if (count !== 4'd0 || total !== 8'd0) begin
            bad_n++; $display("FAIL abort_state got %0d/%0d want 0/0", count, total);
        end
        total_n++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad_n++; $display("FAIL abort_ready got ready=%b busy=%b want 1/0", req_ready, busy);
        end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid === 1'b1) seen++;
            @(negedge clk);
        end
        total_n++; if (seen != 0) begin bad_n++; $display("FAIL abort_no_resp got %0d pulses want 0", seen); end
    endtask

    task automatic test_back_to_back();
        bit rdy, acc1, acc2, bb1, bb2, ra1, ra2;
        int f1, f2, p1, p2, e1, e2, pr1, pr2;
        logic [1:0] er1, er2; logic [7:0] pc1, pc2; logic [3:0] c1, c2; logic [7:0] t1, t2; logic em1, em2;
        time ta1, ta2;
        do_load(15, 0, 1'b0, rdy);
        run_txn(1'b1, 1, 1, 1'b0, acc1, f1, p1, er1, pc1, c1, t1, em1, bb1, ra1, ta1);
        model_txn(1'b1, 1, 1, e1, pr1);
        run_txn(1'b1, 2, 2, 1'b0, acc2, f2, p2, er2, pc2, c2, t2, em2, bb2, ra2, ta2);
        model_txn(1'b1, 2, 2, e2, pr2);
        total_n++; if (!acc1 || !acc2 || (ta2 - ta1) != 70) begin
            bad_n++; $display("FAIL b2b_period got %0t acc=%0d%0d want 70 acc=11", ta2 - ta1, acc1, acc2);
        end
        total_n++; if (er2 !== 2'(e2) || pc2 !== 8'(pr2) || c2 !== 4'(m_count) || t2 !== 8'(m_total)) begin
            bad_n++; $display("FAIL b2b_second got %b/%0d/%0d/%0d want %0d/%0d/%0d/%0d", er2, pc2, c2, t2, e2, pr2, m_count, m_total);
        end
    endtask

    task automatic test_random();
        bit acc, busy_bad, rdy_after, rdy, op;
        int first, pulses, e_err, e_price, qty, up;
        logic [1:0] o_err; logic [7:0] o_price; logic [3:0] o_cnt; logic [7:0] o_tot; logic o_empty;
        time t_acc;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_load($urandom_range(0, 15), $urandom_range(0, 255), 1'($urandom), rdy);
            end else begin
                op  = 1'($urandom);
                qty = $urandom_range(0, 15);
                up  = $urandom_range(0, 15);
                run_txn(op, qty, up, 1'b0, acc, first, pulses, o_err, o_price, o_cnt, o_tot, o_empty,
                        busy_bad, rdy_after, t_acc);
                model_txn(op, qty, up, e_err, e_price);
                total_n++;
                if (!acc || first != 6 || pulses != 1 || o_err !== 2'(e_err) || o_price !== 8'(e_price) ||
                    o_cnt !== 4'(m_count) || o_tot !== 8'(m_total) || o_empty !== (m_count == 0) ||
                    busy_bad || !rdy_after) begin
                    bad_n++;
                    $display("FAIL rand%0d op=%0d q=%0d u=%0d got cyc=%0d n=%0d err=%b pr=%0d cnt=%0d tot=%0d emp=%b want cyc=6 n=1 err=%0d pr=%0d cnt=%0d tot=%0d emp=%0d",
                             i, op, qty, up, first, pulses, o_err, o_price, o_cnt, o_tot, o_empty,
                             e_err, e_price, m_count, m_total, (m_count == 0));
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1; load = 1'b0; load_ct = '0; load_total = '0;
        req_valid = 1'b0; req_op = 1'b0; req_qty = '0; req_uprice = '0;
        test_reset();
        @(negedge clk);
        test_spec_vectors();
        test_load_priority();
        test_load_busy();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
